// File: rtl/cond_pkg.sv
// Shared condition-code encodings, NZCV bit positions and the ARM condition decode.
// Optional macro COND_NV_NEVER_EN makes cond 4'hF (NV) never pass instead of acting as AL.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n    = nzcv[FLAG_N];
    z    = nzcv[FLAG_Z];
    c    = nzcv[FLAG_C];
    v    = nzcv[FLAG_V];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
`ifdef COND_NV_NEVER_EN
      COND_NV: pass = 1'b0;
`else
      COND_NV: pass = 1'b1;
`endif
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/cond_lane.sv
// One condition lane: decodes its condition against the shared flags and registers
// the result for exactly one cycle.
module cond_lane
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       valid_o,
  output logic       pass_o
);

  logic valid_q, pass_q, pass_d;

  assign pass_d = accept_i & cond_pass(cond_i, nzcv_i);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      valid_q <= accept_i;
      pass_q  <= pass_d;
    end
  end

  assign valid_o = valid_q;
  assign pass_o  = pass_q;

endmodule

// File: rtl/cond_eval_unit.sv
// Multi-lane ARM condition evaluator owning the NZCV register and an outstanding
// flag-writer counter. Optional macro COND_NV_NEVER_EN (see cond_pkg) selects NV behaviour.
module cond_eval_unit #(
  parameter int         NUM_LANES = 2,
  parameter int         PEND_W    = 3,
  parameter int         BYPASS    = 1,
  parameter logic [3:0] SR_RESET  = 4'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flag_we,
  input  logic [3:0]             flag_mask,
  input  logic [3:0]             flag_in,
  input  logic                   pend_inc,
  input  logic                   pend_dec,
  input  logic [NUM_LANES-1:0]   lane_valid,
  input  logic [4*NUM_LANES-1:0] lane_cond,
  output logic                   lane_ready,
  output logic [NUM_LANES-1:0]   out_valid,
  output logic [NUM_LANES-1:0]   out_pass,
  output logic [3:0]             sr_out,
  output logic [PEND_W-1:0]      pend_cnt,
  output logic                   pend_err
);

  logic [3:0]        sr_q, sr_d, eff_flags;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;

  assign sr_d      = flag_we ? ((sr_q & ~flag_mask) | (flag_in & flag_mask)) : sr_q;
  assign eff_flags = ((BYPASS != 0) && flag_we) ? sr_d : sr_q;

  // Ready comes only from registered state (and reset), never from this cycle's pend_inc.
  assign lane_ready = rst_n & (pend_q == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pend_d = pend_q;
    err_d  = err_q;
    case ({pend_inc, pend_dec})
      2'b10: begin
        if (pend_q == '1) err_d = 1'b1;
        else              pend_d = pend_q + PEND_W'(1);
      end
      2'b01: begin
        if (pend_q == '0) err_d = 1'b1;
        else              pend_d = pend_q - PEND_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= SR_RESET;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    cond_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept_i (lane_valid[i] & lane_ready),
      .cond_i   (lane_cond[4*i +: 4]),
      .nzcv_i   (eff_flags),
      .valid_o  (out_valid[i]),
      .pass_o   (out_pass[i])
    );
  end

  assign sr_out   = sr_q;
  assign pend_cnt = pend_q;
  assign pend_err = err_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Self-checking bench for cond_eval_unit: one bypassing and one non-bypassing instance
// driven in lockstep and compared against a flag/counter reference model.
module tb_cond_eval_unit;

`ifdef COND_NV_NEVER_EN
  localparam logic NV_EXP = 1'b0;
`else
  localparam logic NV_EXP = 1'b1;
`endif
  localparam int PMAX = 7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag_we, pend_inc, pend_dec;
  logic [3:0] flag_mask, flag_in;
  logic [1:0] lane_valid;
  logic [7:0] lane_cond;

  logic       rdy_a, rdy_b, err_a, err_b;
  logic [1:0] ov_a, ov_b, op_a, op_b;
  logic [3:0] sr_a, sr_b;
  logic [2:0] pc_a, pc_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = bypassing instance, 1 = registered-flags instance
  logic [3:0] m_sr [2];
  int         m_pend [2];
  logic       m_err [2];
  logic [1:0] m_v [2];
  logic [1:0] m_p [2];

  always #5 clk = ~clk;

  cond_eval_unit #(.NUM_LANES(2), .PEND_W(3), .BYPASS(1), .SR_RESET(4'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
    .pend_inc(pend_inc), .pend_dec(pend_dec), .lane_valid(lane_valid), .lane_cond(lane_cond),
    .lane_ready(rdy_a), .out_valid(ov_a), .out_pass(op_a), .sr_out(sr_a),
    .pend_cnt(pc_a), .pend_err(err_a)
  );

  cond_eval_unit #(.NUM_LANES(2), .PEND_W(3), .BYPASS(0), .SR_RESET(4'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_mask(flag_mask), .flag_in(flag_in),
    .pend_inc(pend_inc), .pend_dec(pend_dec), .lane_valid(lane_valid), .lane_cond(lane_cond),
    .lane_ready(rdy_b), .out_valid(ov_b), .out_pass(op_b), .sr_out(sr_b),
    .pend_cnt(pc_b), .pend_err(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ARM condition rules written straight from the flag semantics
  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;            4'h1: return !z;
      4'h2: return c;            4'h3: return !c;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return c && !z;      4'h9: return !c || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return NV_EXP;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sr[d] = 4'h0; m_pend[d] = 0; m_err[d] = 1'b0; m_v[d] = 2'b00; m_p[d] = 2'b00;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s/%0d out_valid", tag, d), (d == 0) ? ov_a : ov_b, m_v[d]);
      check($sformatf("%s/%0d out_pass", tag, d), (d == 0) ? op_a : op_b, m_p[d]);
      check($sformatf("%s/%0d sr_out", tag, d), (d == 0) ? sr_a : sr_b, m_sr[d]);
      check($sformatf("%s/%0d pend_cnt", tag, d), (d == 0) ? pc_a : pc_b, m_pend[d]);
      check($sformatf("%s/%0d pend_err", tag, d), (d == 0) ? err_a : err_b, m_err[d]);
      check($sformatf("%s/%0d lane_ready", tag, d), (d == 0) ? rdy_a : rdy_b,
            (rst_n && m_pend[d] == 0) ? 1 : 0);
    end
  endtask

  // Advance one clock: predict from current inputs, then compare just after the edge
  task automatic step(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic       ready;
      logic [3:0] nxt, eff;
      ready = (m_pend[d] == 0);
      nxt   = flag_we ? ((m_sr[d] & ~flag_mask) | (flag_in & flag_mask)) : m_sr[d];
      eff   = (d == 0 && flag_we) ? nxt : m_sr[d];
      for (int l = 0; l < 2; l++) begin
        logic [3:0] c;
        c = lane_cond[4*l +: 4];
        m_v[d][l] = lane_valid[l] && ready;
        m_p[d][l] = lane_valid[l] && ready && ref_pass(c, eff);
      end
      m_sr[d] = nxt;
      if (pend_inc && !pend_dec) begin
        if (m_pend[d] == PMAX) m_err[d] = 1'b1;
        else m_pend[d]++;
      end else if (pend_dec && !pend_inc) begin
        if (m_pend[d] == 0) m_err[d] = 1'b1;
        else m_pend[d]--;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    flag_we = 0; flag_mask = 0; flag_in = 0; pend_inc = 0; pend_dec = 0;
    lane_valid = 0; lane_cond = 0;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] mask;
    logic [3:0] fin;
    logic [1:0] valid;
    logic [7:0] cond;
    logic [1:0] exp_valid;
    logic [1:0] exp_pass;
    logic [3:0] exp_sr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 4'hF, 4'b0100, 2'b11, 8'h10, 2'b11, 2'b01, 4'b0100};
    vecs[1] = '{1'b1, 4'hF, 4'b1001, 2'b00, 8'h00, 2'b00, 2'b00, 4'b1001};
    vecs[2] = '{1'b1, 4'b0010, 4'b1111, 2'b01, 8'h0A, 2'b01, 2'b01, 4'b1011};
    vecs[3] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'h8C, 2'b11, 2'b11, 4'b1011};
    vecs[4] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'hDB, 2'b11, 2'b00, 4'b1011};
    vecs[5] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'hE9, 2'b11, 2'b10, 4'b1011};
    vecs[6] = '{1'b1, 4'b1100, 4'b0100, 2'b11, 8'h32, 2'b11, 2'b01, 4'b0111};
    vecs[7] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'h54, 2'b11, 2'b10, 4'b0111};
    vecs[8] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'h76, 2'b11, 2'b01, 4'b0111};
    vecs[9] = '{1'b0, 4'h0, 4'h0, 2'b11, 8'hEF, 2'b11, {1'b1, NV_EXP}, 4'b0111};

    // Reset and release with no traffic
    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("in_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all("released");
    step("quiet");

    // Table-driven vectors on an idle counter
    for (int i = 0; i < 10; i++) begin
      flag_we = vecs[i].we; flag_mask = vecs[i].mask; flag_in = vecs[i].fin;
      lane_valid = vecs[i].valid; lane_cond = vecs[i].cond;
      step($sformatf("vec%0d", i));
      check($sformatf("tbl%0d valid", i), ov_a, vecs[i].exp_valid);
      check($sformatf("tbl%0d pass", i), op_a, vecs[i].exp_pass);
      check($sformatf("tbl%0d sr", i), sr_a, vecs[i].exp_sr);
    end

    // Outstanding writer blocks acceptance; retiring it together with a flag write
    idle();
    pend_inc = 1; lane_valid = 2'b11; lane_cond = 8'hEE;
    step("pend_issue");
    check("pend_blocks_ready", rdy_a, 0);
    pend_inc = 0;
    step("pend_ignored");
    check("pend_ignored_valid", ov_a, 2'b00);
    pend_dec = 1; flag_we = 1; flag_mask = 4'hF; flag_in = 4'b0100; lane_cond = 8'h10;
    step("pend_retire");
    check("retire_ready", rdy_a, 1);
    pend_dec = 0; flag_we = 0;
    step("after_retire");
    check("after_retire_pass", op_a, 2'b01);

    // Counter saturation and sticky error
    idle();
    pend_inc = 1;
    for (int i = 0; i < 8; i++) step($sformatf("inc%0d", i));
    check("sat_cnt", pc_a, PMAX);
    check("sat_err", err_a, 1);
    pend_dec = 1;
    step("inc_dec");
    check("inc_dec_cnt", pc_a, PMAX);
    pend_inc = 0;
    for (int i = 0; i < 8; i++) step($sformatf("dec%0d", i));
    check("under_cnt", pc_a, 0);
    check("under_err", err_a, 1);

    // Randomised traffic against the model
    idle();
    for (int i = 0; i < 400; i++) begin
      flag_we    = ($urandom_range(2) == 0);
      flag_mask  = 4'($urandom);
      flag_in    = 4'($urandom);
      pend_inc   = ($urandom_range(5) == 0);
      pend_dec   = ($urandom_range(4) == 0);
      lane_valid = 2'($urandom);
      lane_cond  = 8'($urandom);
      step($sformatf("rnd%0d", i));
    end

    // Reset asserted mid-cycle takes effect immediately
    idle();
    pend_inc = 1; flag_we = 1; flag_mask = 4'hF; flag_in = 4'b1010;
    lane_valid = 2'b11; lane_cond = 8'hEE;
    step("pre_reset");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lane_valid = 2'b11; lane_cond = 8'hE0;
    step("first_after_reset");
    check("first_accept", ov_a, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_eval_unit.md
Name: cond_eval_unit

Overview:
- Parametrised multi-lane condition evaluator with an owned NZCV status register.
- Sits between decode and execute in the ARM core and evaluates the 4-bit condition field for up to NUM_LANES instructions per cycle.
- Holds the NZCV flags, supports masked flag writes with optional same-cycle bypass, and stalls evaluation while flag-producing multi-cycle ops are outstanding.

Parameters:
- NUM_LANES, 2, number of parallel condition lanes (1..4).
- PEND_W, 3, width of the outstanding-flag-writer counter.
- BYPASS, 1, when 1, lanes see flags written in the same cycle; when 0, lanes see the registered flags.
- SR_RESET, 4'h0, reset value of NZCV.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flag_we  in  1  flag write strobe.
- flag_mask  in  4  per-flag write enable, bits [3:0] = N,Z,C,V.
- flag_in  in  4  new flag values, same bit order.
- pend_inc  in  1  a multi-cycle flag writer was issued.
- pend_dec  in  1  a multi-cycle flag writer retired.
- lane_valid  in  NUM_LANES  request valid per lane.
- lane_cond  in  4*NUM_LANES  condition code; lane i uses bits [4i+3:4i].
- lane_ready  out  1  requests are accepted this cycle (common to all lanes).
- out_valid  out  NUM_LANES  registered result valid.
- out_pass  out  NUM_LANES  registered condition-pass result.
- sr_out  out  4  current NZCV register.
- pend_cnt  out  PEND_W  outstanding writer count.
- pend_err  out  1  sticky counter over/underflow flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - sr_out=SR_RESET; pend_cnt=0; pend_err=0.
  - out_valid=0; out_pass=0.
  - lane_ready=0 while in reset, then 1 after release (because pend_cnt=0).
- Flag register: on a clock edge with flag_we=1, sr_next = (sr & ~flag_mask) | (flag_in & flag_mask). When flag_we=0, sr holds.
- Effective flags (eff):
  - BYPASS=1 and flag_we=1: eff = sr_next.
  - Otherwise: eff = sr.
- Condition decode, applied to eff (N=3, Z=2, C=1, V=0):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z & N==V
  - D LE: Z | N!=V
  - E AL: 1
  - F: see Optional Feature.
- lane_ready = (pend_cnt==0). It is combinational from registered state only and does not depend on pend_inc in the same cycle.
- Latency is 1 cycle. At each edge:
  - out_valid[i] <= lane_valid[i] & lane_ready.
  - out_pass[i] <= decode(lane_cond[i], eff) & lane_valid[i] & lane_ready.
  - Lanes that are not accepted produce out_valid=0 and out_pass=0.
  - Outputs hold for exactly one cycle; there is no backpressure on outputs.
- Pending counter:
  - inc only: pend_cnt+1.
  - dec only: pend_cnt-1.
  - inc and dec together: unchanged.
  - inc at all-ones: count holds and pend_err is set.
  - dec at zero: count holds and pend_err is set.
  - pend_err clears only on reset.
- flag_we while pend_cnt!=0 is legal and updates sr. A retiring writer typically asserts pend_dec and flag_we in the same cycle.
- Lanes are independent; all lanes use the same eff in a given cycle.
- Reset asserted mid-operation discards in-flight results and clears the counter; the first accept is possible in the first cycle after release.

Optional Feature:
- Macro: COND_NV_NEVER_EN.
  - Defined: cond 4'hF (NV) evaluates to 0, matching the ARMv4 "never" condition.
  - Undefined: cond 4'hF evaluates to 1, the same as AL.

Decomposition:
- Shared package cond_pkg:
  - Condition encodings COND_EQ..COND_NV as 4-bit localparams.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - A pure function cond_pass(cond, nzcv).
- One natural sub-module, cond_lane: combinational decode for one lane plus its output register, instantiated NUM_LANES times via generate.
- The flag register and pending counter stay in the top level.

Test Plan:
- Reset then release, no traffic -> sr_out=SR_RESET, pend_cnt=0, pend_err=0, lane_ready=1, out_valid=0.
- flag_we=1, mask=4'hF, flag_in=4'b0100, lane0 cond=0 (EQ), lane1 cond=1 (NE), BYPASS=1 -> next cycle out_valid=2'b11, out_pass=2'b01, sr_out=4'b0100. With BYPASS=0 and sr=0, out_pass=2'b10.
- sr=4'b1001 then flag_we with mask=4'b0010, flag_in=4'b1111 -> sr_out=4'b1011. Then lane0 cond=A (GE) -> out_pass[0]=1; cond=C (GT) -> 1; cond=8 (HI) -> 1.
- pend_inc pulse -> lane_ready=0 next cycle, lane_valid=2'b11 ignored (out_valid=0). Then pend_dec together with flag_we -> pend_cnt=0, lane_ready=1 on the following cycle, and lanes evaluate with the new flags.
- PEND_W=3: 8 pend_inc pulses -> pend_cnt stays 7, pend_err=1. Then simultaneous inc and dec -> count unchanged. Then dec to 0 plus one extra dec -> pend_cnt=0, pend_err still 1.
- cond=F with and without COND_NV_NEVER_EN -> out_pass=0 and 1 respectively. Also assert rst_n mid-stream -> all outputs return to reset values immediately, without waiting for a clock edge.
